// File: rtl/fsm_timer_multi.sv
// fsm_timer_multi: prescaled one-shot/periodic down-counter timer with pause and abort.
module fsm_timer_multi #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             RESTART,
    input  logic             PAUSE,
    input  logic             MODE,
    input  logic [WIDTH-1:0] PERIOD,
    output logic             RDY,
    output logic             BUSY,
    output logic             TICK,
    output logic [WIDTH-1:0] COUNT
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        RUNNING = 4'b0010,
        PAUSED  = 4'b0100,
        EXPIRED = 4'b1000
    } state_t;

    state_t state, state_nx;
    logic [WIDTH-1:0] per, per_nx, count_nx, per_in;
    logic [PW-1:0] pre, pre_nx;
    logic mode, mode_nx, tick_nx, strobe;

    assign per_in = (PERIOD == '0) ? WIDTH'(1) : PERIOD;
    assign strobe = (pre == PRE_MAX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            COUNT <= '0;
            pre   <= '0;
            TICK  <= 1'b0;
            per   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            COUNT <= count_nx;
            pre   <= pre_nx;
            TICK  <= tick_nx;
            per   <= per_nx;
            mode  <= mode_nx;
        end
    end

    // A PAUSED edge with PAUSE low already advances, so a pause costs exactly its length.
    always_comb begin
        state_nx = state;
        count_nx = COUNT;
        pre_nx   = pre;
        tick_nx  = 1'b0;
        per_nx   = per;
        mode_nx  = mode;
        if (RESTART) begin
            state_nx = IDLE;
            count_nx = '0;
            pre_nx   = '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    state_nx = RUNNING;
                    per_nx   = per_in;
                    mode_nx  = MODE;
                    count_nx = per_in - WIDTH'(1);
                    pre_nx   = '0;
                end
                RUNNING, PAUSED: if (PAUSE) begin
                    state_nx = PAUSED;
                end else begin
                    state_nx = RUNNING;
                    pre_nx   = strobe ? '0 : pre + PW'(1);
                    if (strobe && COUNT != '0) begin
                        count_nx = COUNT - WIDTH'(1);
                    end else if (strobe) begin
                        tick_nx  = 1'b1;
                        count_nx = mode ? per - WIDTH'(1) : '0;
                        state_nx = mode ? RUNNING : EXPIRED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        RDY  = (state == EXPIRED);
        BUSY = (state == RUNNING) || (state == PAUSED);
    end
endmodule

// File: tb/tb_fsm_timer_multi.sv
// tb_fsm_timer_multi: directed checks of fsm_timer_multi at PRESCALE=1 and PRESCALE=4.
module tb_fsm_timer_multi;
    logic clk = 1'b0;
    logic rst, start, restart, pause, mode;
    logic [7:0] period;
    logic rdy, busy, tick;
    logic [7:0] count;
    logic start4, restart4;
    logic [7:0] period4;
    logic rdy4, busy4, tick4;
    logic [7:0] count4;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsm_timer_multi #(.WIDTH(8), .PRESCALE(1)) dut (
        .CLK(clk), .RESET(rst), .START(start), .RESTART(restart), .PAUSE(pause),
        .MODE(mode), .PERIOD(period), .RDY(rdy), .BUSY(busy), .TICK(tick), .COUNT(count)
    );

    fsm_timer_multi #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .CLK(clk), .RESET(rst), .START(start4), .RESTART(restart4), .PAUSE(1'b0),
        .MODE(1'b0), .PERIOD(period4), .RDY(rdy4), .BUSY(busy4), .TICK(tick4), .COUNT(count4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " count"}, 32'(count), 0);
        chk({tag, " rdy"}, 32'(rdy), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " tick"}, 32'(tick), 0);
    endtask

    task automatic launch(input logic [7:0] p, input logic m);
        period = p; mode = m; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic abort();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; restart = 1'b0; pause = 1'b0; mode = 1'b0; period = 8'd0;
        start4 = 1'b0; restart4 = 1'b0; period4 = 8'd0;
        step(); step();
        rst = 1'b0;
        idle_chk("reset");
        chk("reset busy4", 32'(busy4), 0);

        // one-shot PERIOD=5
        launch(8'd5, 1'b0);
        chk("t1 count e0", 32'(count), 4);
        chk("t1 busy e0", 32'(busy), 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("t1 count e%0d", k), 32'(count), 32'(4 - k));
            chk($sformatf("t1 rdy e%0d", k), 32'(rdy), 0);
        end
        step();
        chk("t1 rdy e5", 32'(rdy), 1);
        chk("t1 tick e5", 32'(tick), 1);
        chk("t1 busy e5", 32'(busy), 0);
        chk("t1 count e5", 32'(count), 0);
        step();
        chk("t1 tick e6", 32'(tick), 0);
        chk("t1 rdy e6", 32'(rdy), 1);
        launch(8'd9, 1'b1);
        chk("t1 start in expired", 32'(rdy), 1);
        abort();
        idle_chk("t1 restart");

        // periodic PERIOD=3
        launch(8'd3, 1'b1);
        for (int e = 1; e <= 9; e++) begin
            step();
            chk($sformatf("t2 tick e%0d", e), 32'(tick), (e % 3 == 0) ? 1 : 0);
            chk($sformatf("t2 rdy e%0d", e), 32'(rdy), 0);
            chk($sformatf("t2 busy e%0d", e), 32'(busy), 1);
        end
        chk("t2 count e9", 32'(count), 2);
        abort();
        idle_chk("t2 restart");

        // one-shot PERIOD=6 paused for 4 edges from edge 2
        launch(8'd6, 1'b0);
        step();
        chk("t3 count e1", 32'(count), 4);
        pause = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            step();
            chk($sformatf("t3 frozen e%0d", e), 32'(count), 4);
            chk($sformatf("t3 busy e%0d", e), 32'(busy), 1);
            chk($sformatf("t3 tick e%0d", e), 32'(tick), 0);
        end
        pause = 1'b0;
        for (int e = 6; e <= 9; e++) begin
            step();
            chk($sformatf("t3 count e%0d", e), 32'(count), 32'(9 - e));
            chk($sformatf("t3 rdy e%0d", e), 32'(rdy), 0);
        end
        step();
        chk("t3 rdy e10", 32'(rdy), 1);
        chk("t3 tick e10", 32'(tick), 1);
        abort();

        // START with RESTART in IDLE, START mid-run, PERIOD changed mid-run
        start = 1'b1; restart = 1'b1; period = 8'd4;
        step();
        start = 1'b0; restart = 1'b0;
        idle_chk("t5 start+restart");
        launch(8'd4, 1'b0);
        chk("t5 count e0", 32'(count), 3);
        period = 8'd9; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t5 count e1", 32'(count), 2);
        step(); step();
        chk("t5 count e3", 32'(count), 0);
        chk("t5 rdy e3", 32'(rdy), 0);
        step();
        chk("t5 rdy e4", 32'(rdy), 1);
        abort();

        // PERIOD = 2**WIDTH-1
        launch(8'd255, 1'b0);
        chk("max count e0", 32'(count), 254);
        abort();

        // reset while paused and while expired
        launch(8'd5, 1'b0);
        pause = 1'b1;
        step();
        chk("t6 paused busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0; pause = 1'b0;
        idle_chk("t6 reset paused");
        launch(8'd1, 1'b0);
        step();
        chk("t6 expired rdy", 32'(rdy), 1);
        chk("t6 expired tick", 32'(tick), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_chk("t6 reset expired");
        launch(8'd2, 1'b0);
        step();
        chk("t6 rerun rdy e1", 32'(rdy), 0);
        step();
        chk("t6 rerun rdy e2", 32'(rdy), 1);
        abort();

        // PRESCALE=4: PERIOD=2 then PERIOD=0
        period4 = 8'd2; start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("t4 count4 e0", 32'(count4), 1);
        for (int e = 1; e <= 7; e++) begin
            step();
            chk($sformatf("t4 rdy4 e%0d", e), 32'(rdy4), 0);
            chk($sformatf("t4 count4 e%0d", e), 32'(count4), (e >= 4) ? 0 : 1);
        end
        step();
        chk("t4 rdy4 e8", 32'(rdy4), 1);
        chk("t4 tick4 e8", 32'(tick4), 1);
        restart4 = 1'b1;
        step();
        restart4 = 1'b0;
        chk("t4 restart busy4", 32'(busy4), 0);
        period4 = 8'd0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("t4 p0 count4 e0", 32'(count4), 0);
        for (int e = 1; e <= 3; e++) begin
            step();
            chk($sformatf("t4 p0 rdy4 e%0d", e), 32'(rdy4), 0);
        end
        step();
        chk("t4 p0 rdy4 e4", 32'(rdy4), 1);
        chk("t4 p0 tick4 e4", 32'(tick4), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
